multicycle_control: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 39 +++
 rtl/multicycle_control.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared constants for the multicycle control FSM
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle datapath
module multicycle_control
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       ALUOp1,
   output logic       ALUOp0,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic       instr_done,
   output logic       illegal_op
);

   state_t     state;
   state_t     next_state;

   logic [1:0] alu_op;
   logic       pc_write;
   logic       pc_write_cond;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_source;
   logic       done;
   logic       illegal;

   // State register; reset returns to FETCH immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and output decode; memory states wait on mem_ready.
   always_comb begin
      next_state    = FETCH;
      alu_op        = ALUOP_ADD;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      pc_source     = PCSRC_ALU;
      done          = 1'b0;
      illegal       = 1'b0;
      case (state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               pc_write   = 1'b1;
               ir_write   = 1'b1;
               next_state = DECODE;
            end else begin
               next_state = FETCH;
            end
         end
         DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            case (opcode)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_RTYPE:     next_state = EXEC;
               OP_BEQ:       next_state = BRANCH;
               OP_ADDI:      next_state = ADDIEX;
               OP_J:         next_state = JUMP;
               default: begin
                  next_state = FETCH;
                  illegal    = 1'b1;
                  done       = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            // Opcode is sampled again here; anything but lw/sw abandons the access.
            if (opcode == OP_LW) begin
               next_state = MEMRD;
            end else if (opcode == OP_SW) begin
               next_state = MEMWR;
            end else begin
               next_state = FETCH;
            end
         end
         MEMRD: begin
            mem_read   = 1'b1;
            i_or_d     = 1'b1;
            next_state = mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            done       = 1'b1;
         end
         MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               done       = 1'b1;
               next_state = FETCH;
            end else begin
               next_state = MEMWR;
            end
         end
         EXEC: begin
            alu_src_a  = 1'b1;
            alu_op     = ALUOP_FUNCT;
            next_state = ALUWB;
         end
         ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            done      = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            done          = 1'b1;
         end
         ADDIEX: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            next_state = ADDIWB;
         end
         ADDIWB: begin
            reg_write = 1'b1;
            done      = 1'b1;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
            done      = 1'b1;
         end
         default: begin
            next_state = FETCH;
         end
      endcase
   end

   // Outputs are gated by reset so nothing reaches memory or registers mid-reset.
   assign ALUOp1      = rst_n & alu_op[1];
   assign ALUOp0      = rst_n & alu_op[0];
   assign PCWrite     = rst_n & pc_write;
   assign PCWriteCond = rst_n & pc_write_cond;
   assign IorD        = rst_n & i_or_d;
   assign MemRead     = rst_n & mem_read;
   assign MemWrite    = rst_n & mem_write;
   assign IRWrite     = rst_n & ir_write;
   assign MemtoReg    = rst_n & mem_to_reg;
   assign RegDst      = rst_n & reg_dst;
   assign RegWrite    = rst_n & reg_write;
   assign ALUSrcA     = rst_n & alu_src_a;
   assign ALUSrcB     = rst_n ? alu_src_b : 2'b00;
   assign PCSource    = rst_n ? pc_source : 2'b00;
   assign instr_done  = rst_n & done;
   assign illegal_op  = rst_n & illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       ALUOp1, ALUOp0, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
   logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
   logic [1:0] ALUSrcB, PCSource;
   logic [17:0] outs;

   int total = 0;
   int bad = 0;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   assign outs = {ALUOp1, ALUOp0, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, instr_done, illegal_op};

   localparam logic [17:0] M_AOP1 = 18'h1 << 17;
   localparam logic [17:0] M_AOP0 = 18'h1 << 16;
   localparam logic [17:0] M_PCW  = 18'h1 << 15;
   localparam logic [17:0] M_PCWC = 18'h1 << 14;
   localparam logic [17:0] M_IORD = 18'h1 << 13;
   localparam logic [17:0] M_MR   = 18'h1 << 12;
   localparam logic [17:0] M_MW   = 18'h1 << 11;
   localparam logic [17:0] M_IRW  = 18'h1 << 10;
   localparam logic [17:0] M_M2R  = 18'h1 << 9;
   localparam logic [17:0] M_RD   = 18'h1 << 8;
   localparam logic [17:0] M_RW   = 18'h1 << 7;
   localparam logic [17:0] M_SA   = 18'h1 << 6;
   localparam logic [17:0] M_SB01 = 18'h1 << 4;
   localparam logic [17:0] M_SB10 = 18'h2 << 4;
   localparam logic [17:0] M_SB11 = 18'h3 << 4;
   localparam logic [17:0] M_PS01 = 18'h1 << 2;
   localparam logic [17:0] M_PS10 = 18'h2 << 2;
   localparam logic [17:0] M_DONE = 18'h2;
   localparam logic [17:0] M_ILL  = 18'h1;

   localparam logic [17:0] E_ZERO     = 18'h0;
   localparam logic [17:0] E_FETCH_W  = M_MR | M_SB01;
   localparam logic [17:0] E_FETCH_R  = M_MR | M_SB01 | M_PCW | M_IRW;
   localparam logic [17:0] E_DECODE   = M_SB11;
   localparam logic [17:0] E_DEC_ILL  = M_SB11 | M_DONE | M_ILL;
   localparam logic [17:0] E_MEMADR   = M_SA | M_SB10;
   localparam logic [17:0] E_MEMRD    = M_MR | M_IORD;
   localparam logic [17:0] E_MEMWB    = M_RW | M_M2R | M_DONE;
   localparam logic [17:0] E_MEMWR_W  = M_MW | M_IORD;
   localparam logic [17:0] E_MEMWR_R  = M_MW | M_IORD | M_DONE;
   localparam logic [17:0] E_EXEC     = M_SA | M_AOP1;
   localparam logic [17:0] E_ALUWB    = M_RW | M_RD | M_DONE;
   localparam logic [17:0] E_BRANCH   = M_SA | M_AOP0 | M_PCWC | M_PS01 | M_DONE;
   localparam logic [17:0] E_ADDIEX   = M_SA | M_SB10;
   localparam logic [17:0] E_ADDIWB   = M_RW | M_DONE;
   localparam logic [17:0] E_JUMP     = M_PCW | M_PS10 | M_DONE;

   localparam logic [5:0] RT = 6'b000000;
   localparam logic [5:0] LW = 6'b100011;
   localparam logic [5:0] SW = 6'b101011;
   localparam logic [5:0] BQ = 6'b000100;
   localparam logic [5:0] AI = 6'b001000;
   localparam logic [5:0] JP = 6'b000010;
   localparam logic [5:0] BAD = 6'b111111;

   // Reset gating, including an asynchronous reset while sitting in FETCH.
   task automatic test_reset();
      rst_n = 1'b0;
      mem_ready = 1'b0;
      opcode = RT;
      #3;
      total++;
      if (outs !== E_ZERO) begin
         bad++;
         $display("FAIL reset_hold: got %h want %h", outs, E_ZERO);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (outs !== E_FETCH_W) begin
         bad++;
         $display("FAIL reset_release_fetch: got %h want %h", outs, E_FETCH_W);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (outs !== E_ZERO) begin
         bad++;
         $display("FAIL reset_mid_fetch: got %h want %h", outs, E_ZERO);
      end
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (outs !== E_FETCH_W) begin
         bad++;
         $display("FAIL reset_refetch: got %h want %h", outs, E_FETCH_W);
      end
      @(posedge clk);
      #1;
   endtask

   // R-type; mem_ready low and opcode changes after DECODE are ignored.
   task automatic test_rtype();
      logic [5:0]  op [4];
      logic        mr [4];
      logic [17:0] ex [4];
      op = '{RT, RT, LW, LW};
      mr = '{1'b1, 1'b0, 1'b0, 1'b1};
      ex = '{E_FETCH_R, E_DECODE, E_EXEC, E_ALUWB};
      for (int i = 0; i < 4; i++) begin
         opcode = op[i];
         mem_ready = mr[i];
         @(negedge clk);
         total++;
         if (outs !== ex[i]) begin
            bad++;
            $display("FAIL rtype row %0d: got %h want %h", i, outs, ex[i]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // lw with two wait cycles in MEMRD: seven cycles total.
   task automatic test_lw_wait();
      logic [5:0]  op [7];
      logic        mr [7];
      logic [17:0] ex [7];
      op = '{LW, LW, LW, LW, LW, LW, LW};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      ex = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
      for (int i = 0; i < 7; i++) begin
         opcode = op[i];
         mem_ready = mr[i];
         @(negedge clk);
         total++;
         if (outs !== ex[i]) begin
            bad++;
            $display("FAIL lw_wait row %0d: got %h want %h", i, outs, ex[i]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // sw then beq; the sw opcode only appears at MEMADR, which must re-decode it.
   task automatic test_back_to_back();
      logic [5:0]  op [7];
      logic        mr [7];
      logic [17:0] ex [7];
      op = '{SW, LW, SW, SW, BQ, BQ, BQ};
      mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      ex = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR_R, E_FETCH_R, E_DECODE, E_BRANCH};
      for (int i = 0; i < 7; i++) begin
         opcode = op[i];
         mem_ready = mr[i];
         @(negedge clk);
         total++;
         if (outs !== ex[i]) begin
            bad++;
            $display("FAIL back_to_back row %0d: got %h want %h", i, outs, ex[i]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // sw with a FETCH wait and a MEMWR wait: request held, done only on ready.
   task automatic test_sw_wait();
      logic [5:0]  op [6];
      logic        mr [6];
      logic [17:0] ex [6];
      op = '{SW, SW, SW, SW, SW, SW};
      mr = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      ex = '{E_FETCH_W, E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR_W, E_MEMWR_R};
      for (int i = 0; i < 6; i++) begin
         opcode = op[i];
         mem_ready = mr[i];
         @(negedge clk);
         total++;
         if (outs !== ex[i]) begin
            bad++;
            $display("FAIL sw_wait row %0d: got %h want %h", i, outs, ex[i]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // addi then j.
   task automatic test_addi_j();
      logic [5:0]  op [7];
      logic        mr [7];
      logic [17:0] ex [7];
      op = '{AI, AI, AI, AI, JP, JP, JP};
      mr = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      ex = '{E_FETCH_R, E_DECODE, E_ADDIEX, E_ADDIWB, E_FETCH_R, E_DECODE, E_JUMP};
      for (int i = 0; i < 7; i++) begin
         opcode = op[i];
         mem_ready = mr[i];
         @(negedge clk);
         total++;
         if (outs !== ex[i]) begin
            bad++;
            $display("FAIL addi_j row %0d: got %h want %h", i, outs, ex[i]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // Unsupported opcodes flag in DECODE and return straight to FETCH.
   task automatic test_illegal();
      logic [5:0]  op [5];
      logic        mr [5];
      logic [17:0] ex [5];
      op = '{BAD, BAD, 6'b000001, 6'b000001, RT};
      mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      ex = '{E_FETCH_R, E_DEC_ILL, E_FETCH_R, E_DEC_ILL, E_FETCH_W};
      for (int i = 0; i < 5; i++) begin
         opcode = op[i];
         mem_ready = mr[i];
         @(negedge clk);
         total++;
         if (outs !== ex[i]) begin
            bad++;
            $display("FAIL illegal row %0d: got %h want %h", i, outs, ex[i]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // Reset while lw is waiting in MEMRD aborts it and restarts in FETCH.
   task automatic test_abort();
      logic [5:0]  op [4];
      logic        mr [4];
      logic [17:0] ex [4];
      op = '{LW, LW, LW, LW};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0};
      ex = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD};
      for (int i = 0; i < 4; i++) begin
         opcode = op[i];
         mem_ready = mr[i];
         @(negedge clk);
         total++;
         if (outs !== ex[i]) begin
            bad++;
            $display("FAIL abort row %0d: got %h want %h", i, outs, ex[i]);
         end
         if (i < 3) begin
            @(posedge clk);
            #1;
         end
      end
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (outs !== E_ZERO) begin
         bad++;
         $display("FAIL abort_gated: got %h want %h", outs, E_ZERO);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (outs !== E_FETCH_W) begin
         bad++;
         $display("FAIL abort_refetch: got %h want %h", outs, E_FETCH_W);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_wait();
      test_back_to_back();
      test_sw_wait();
      test_addi_j();
      test_illegal();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
